// File: rtl/uart_rx_oversampled.sv
// UART 8N1 receiver with oversampled start/bit-centre detection, a valid/ready
// holding register, and one-clock framing/overrun error pulses.
module uart_rx_oversampled #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t               state, state_next;
  logic                 rx_meta, rx_s;
  logic [CNT_W-1:0]     tick_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 cnt_clr, cnt_inc, idx_clr, shift_en, stop_ok, stop_bad;

  // Sync flops reset high so a reset never looks like a start bit.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    if (baud_tick) begin
      case (state)
        IDLE:      if (!rx_s) state_next = START;
        START:     if (tick_cnt == HALF_LAST) state_next = rx_s ? IDLE : DATA;
        DATA:      if (tick_cnt == BIT_LAST && bit_idx == IDX_LAST) state_next = STOP;
        STOP:      if (tick_cnt == BIT_LAST) state_next = rx_s ? IDLE : WAIT_IDLE;
        WAIT_IDLE: if (rx_s) state_next = IDLE;
        default:   state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    idx_clr  = 1'b0;
    shift_en = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    if (baud_tick) begin
      case (state)
        START: begin
          if (tick_cnt == HALF_LAST) begin
            cnt_clr = 1'b1;
            idx_clr = 1'b1;
          end else cnt_inc = 1'b1;
        end
        DATA: begin
          if (tick_cnt == BIT_LAST) begin
            cnt_clr  = 1'b1;
            shift_en = 1'b1;
          end else cnt_inc = 1'b1;
        end
        STOP: begin
          if (tick_cnt == BIT_LAST) begin
            cnt_clr  = 1'b1;
            stop_ok  = rx_s;
            stop_bad = !rx_s;
          end else cnt_inc = 1'b1;
        end
        default: cnt_clr = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      if (cnt_clr)      tick_cnt <= '0;
      else if (cnt_inc) tick_cnt <= tick_cnt + CNT_W'(1);
      if (idx_clr)       bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + IDX_W'(1);
      // LSB-first line: shift in at the top so the first bit ends in bit 0.
      if (shift_en) shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
    end
  end

  // Holding register: a drain in the same clk frees the slot for a new byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= stop_bad;
      overrun_err <= stop_ok && rx_valid && !rx_ready;
      if (stop_ok && (!rx_valid || rx_ready)) begin
        rx_data  <= shift_reg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: one task per scenario, inline checks,
// negedge monitor collecting handshaken bytes and error pulses.
module tb_uart_rx_oversampled;

  localparam int OS = 16;
  // Ticks from the aligned start edge (tick 0) to the stop-bit sample tick.
  localparam int STOP_TICK = 1 + OS / 2 + OS * 9;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       frame_err;
  logic       overrun_err;

  int checks = 0;
  int errors = 0;
  int tick_div = 54;
  int div_cnt = 0;
  int cyc = 0;
  int align_cyc = 0;
  int frame_cnt = 0;
  int ovr_cnt = 0;
  int low_cnt = 0;
  int rise_cyc = 0;
  logic prev_valid = 1'b0;
  logic [7:0] got[$];

  uart_rx_oversampled #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Tick generator: baud_tick high for one full clk every tick_div clks.
  always @(posedge clk) begin
    #1;
    if (div_cnt >= tick_div - 1) begin
      div_cnt   = 0;
      baud_tick = 1'b1;
    end else begin
      div_cnt   = div_cnt + 1;
      baud_tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    prev_valid <= rx_valid;
    if (rst_n) begin
      if (frame_err)   frame_cnt <= frame_cnt + 1;
      if (overrun_err) ovr_cnt <= ovr_cnt + 1;
      if (!rx_valid)   low_cnt <= low_cnt + 1;
      if (rx_valid && !prev_valid) rise_cyc <= cyc;
      if (rx_valid && rx_ready) got.push_back(rx_data);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_bits(input int n);
    repeat (n * OS * tick_div) step();
  endtask

  task automatic align();
    for (int i = 0; i < 200; i++) begin
      step();
      if (baud_tick === 1'b1) break;
    end
    align_cyc = cyc;
  endtask

  task automatic drive_frame(input logic [7:0] data, input int stop_low);
    rx = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      wait_bits(1);
    end
    if (stop_low > 0) begin
      rx = 1'b0;
      wait_bits(stop_low);
    end
    rx = 1'b1;
    wait_bits(2);
  endtask

  task automatic send_byte(input logic [7:0] data, input int stop_low);
    align();
    drive_frame(data, stop_low);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx = 1'b1;
    rx_ready = 1'b0;
    repeat (4) step();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", rx_data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", frame_err); end
    checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL reset_oerr got %b exp 0", overrun_err); end
    rst_n = 1'b1;
    repeat (4) step();
  endtask

  task automatic test_basic();
    int f0, o0;
    tick_div = 54;
    rx_ready = 1'b1;
    wait_bits(1);
    got.delete();
    f0 = frame_cnt; o0 = ovr_cnt;
    send_byte(8'hA5, 0);
    checks++; if (got.size() != 1 || got[0] !== 8'hA5) begin errors++; $display("FAIL basic_data got n=%0d first=%h exp n=1 A5", got.size(), got.size() ? got[0] : 8'h00); end
    checks++; if (frame_cnt != f0) begin errors++; $display("FAIL basic_ferr got %0d exp 0", frame_cnt - f0); end
    checks++; if (ovr_cnt != o0) begin errors++; $display("FAIL basic_oerr got %0d exp 0", ovr_cnt - o0); end
    checks++; if (rise_cyc != align_cyc + 1 + STOP_TICK * 54) begin errors++; $display("FAIL basic_latency got cyc %0d exp %0d", rise_cyc, align_cyc + 1 + STOP_TICK * 54); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL basic_drained got %b exp 0", rx_valid); end
    tick_div = 8;
    wait_bits(1);
  endtask

  task automatic test_glitch();
    int f0, o0;
    rx_ready = 1'b1;
    got.delete();
    f0 = frame_cnt; o0 = ovr_cnt;
    align();
    rx = 1'b0;
    repeat (4 * tick_div) step();
    rx = 1'b1;
    wait_bits(2);
    checks++; if (got.size() != 0 || rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_no_byte got n=%0d valid=%b exp 0 0", got.size(), rx_valid); end
    checks++; if (frame_cnt != f0 || ovr_cnt != o0) begin errors++; $display("FAIL glitch_no_err got ferr=%0d oerr=%0d exp 0 0", frame_cnt - f0, ovr_cnt - o0); end
    send_byte(8'h3C, 0);
    checks++; if (got.size() != 1 || got[0] !== 8'h3C) begin errors++; $display("FAIL glitch_next got n=%0d first=%h exp n=1 3C", got.size(), got.size() ? got[0] : 8'h00); end
    checks++; if (frame_cnt != f0 || ovr_cnt != o0) begin errors++; $display("FAIL glitch_next_err got ferr=%0d oerr=%0d exp 0 0", frame_cnt - f0, ovr_cnt - o0); end
  endtask

  task automatic test_framing();
    int f0, o0;
    rx_ready = 1'b1;
    got.delete();
    f0 = frame_cnt; o0 = ovr_cnt;
    send_byte(8'h55, 2);
    wait_bits(10);
    checks++; if (frame_cnt - f0 != 1) begin errors++; $display("FAIL frame_pulse got %0d clks exp 1", frame_cnt - f0); end
    checks++; if (got.size() != 0) begin errors++; $display("FAIL frame_discard got n=%0d exp 0", got.size()); end
    checks++; if (ovr_cnt != o0) begin errors++; $display("FAIL frame_oerr got %0d exp 0", ovr_cnt - o0); end
    send_byte(8'h0F, 0);
    checks++; if (got.size() != 1 || got[0] !== 8'h0F) begin errors++; $display("FAIL frame_next got n=%0d first=%h exp n=1 0F", got.size(), got.size() ? got[0] : 8'h00); end
    checks++; if (frame_cnt - f0 != 1) begin errors++; $display("FAIL frame_next_err got %0d exp 1", frame_cnt - f0); end
  endtask

  task automatic test_overrun();
    int f0, o0;
    rx_ready = 1'b0;
    got.delete();
    f0 = frame_cnt; o0 = ovr_cnt;
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin errors++; $display("FAIL ovr_hold got valid=%b data=%h exp 1 11", rx_valid, rx_data); end
    checks++; if (ovr_cnt - o0 != 1) begin errors++; $display("FAIL ovr_pulse got %0d clks exp 1", ovr_cnt - o0); end
    checks++; if (frame_cnt != f0) begin errors++; $display("FAIL ovr_ferr got %0d exp 0", frame_cnt - f0); end
    rx_ready = 1'b1;
    repeat (4) step();
    checks++; if (got.size() != 1 || got[0] !== 8'h11) begin errors++; $display("FAIL ovr_drain got n=%0d first=%h exp n=1 11", got.size(), got.size() ? got[0] : 8'h00); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_empty got %b exp 0", rx_valid); end
  endtask

  task automatic test_back_to_back();
    int o0, l0;
    rx_ready = 1'b0;
    send_byte(8'h11, 0);
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin errors++; $display("FAIL b2b_hold got valid=%b data=%h exp 1 11", rx_valid, rx_data); end
    got.delete();
    o0 = ovr_cnt; l0 = low_cnt;
    align();
    fork
      drive_frame(8'h22, 0);
      begin
        repeat (STOP_TICK * tick_div) step();
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
      end
    join
    checks++; if (ovr_cnt != o0) begin errors++; $display("FAIL b2b_no_ovr got %0d exp 0", ovr_cnt - o0); end
    checks++; if (low_cnt != l0) begin errors++; $display("FAIL b2b_valid_held got %0d low clks exp 0", low_cnt - l0); end
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h22) begin errors++; $display("FAIL b2b_new got valid=%b data=%h exp 1 22", rx_valid, rx_data); end
    checks++; if (got.size() != 1 || got[0] !== 8'h11) begin errors++; $display("FAIL b2b_old got n=%0d first=%h exp n=1 11", got.size(), got.size() ? got[0] : 8'h00); end
    rx_ready = 1'b1;
    repeat (4) step();
    checks++; if (got.size() != 2 || got[1] !== 8'h22) begin errors++; $display("FAIL b2b_drain got n=%0d exp n=2 second=22", got.size()); end
  endtask

  task automatic test_reset_midframe();
    int f0, o0;
    rx_ready = 1'b0;
    send_byte(8'h5A, 0);
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h5A) begin errors++; $display("FAIL rst_pre got valid=%b data=%h exp 1 5A", rx_valid, rx_data); end
    align();
    rx = 1'b0;
    wait_bits(1);
    rx = 1'b1;
    repeat (3 * OS * tick_div + OS * tick_div / 2) step();
    rst_n = 1'b0;
    #1;
    checks++; if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin errors++; $display("FAIL rst_mid_out got valid=%b data=%h exp 0 00", rx_valid, rx_data); end
    checks++; if (frame_err !== 1'b0 || overrun_err !== 1'b0) begin errors++; $display("FAIL rst_mid_err got %b %b exp 0 0", frame_err, overrun_err); end
    repeat (5) step();
    rst_n = 1'b1;
    wait_bits(2);
    got.delete();
    f0 = frame_cnt; o0 = ovr_cnt;
    rx_ready = 1'b1;
    send_byte(8'h81, 0);
    checks++; if (got.size() != 1 || got[0] !== 8'h81) begin errors++; $display("FAIL rst_next got n=%0d first=%h exp n=1 81", got.size(), got.size() ? got[0] : 8'h00); end
    checks++; if (frame_cnt != f0 || ovr_cnt != o0) begin errors++; $display("FAIL rst_next_err got ferr=%0d oerr=%0d exp 0 0", frame_cnt - f0, ovr_cnt - o0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_oversampled.md
Name: uart_rx_oversampled

Overview:
- UART 8N1 receiver clocked by the system clock; advances only on the one-cycle oversample enable from the clock divider, `baud_tick`.
- Synchronises the asynchronous serial line and validates the start bit at mid-bit. Samples each data bit at its centre.
- Delivers each byte through a valid/ready holding register to the downstream command/packet parser. Flags framing and overrun errors.

Parameters:
- DATA_BITS, 8, data bits per frame, sent LSB first.
- OVERSAMPLE, 16, baud_tick pulses per bit period; must be even and ≥4.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- baud_tick  input  1  one-clk enable at OVERSAMPLE × baud rate
- rx  input  1  asynchronous serial line, idle high
- rx_data  output  DATA_BITS  received byte; stable while rx_valid=1
- rx_valid  output  1  byte available
- rx_ready  input  1  consumer accepts byte when rx_valid & rx_ready
- frame_err  output  1  one-clk pulse: stop bit sampled low
- overrun_err  output  1  one-clk pulse: byte completed while holding register full

Behaviour:
- Reset (rst_n=0, async):
  - rx_data=0, rx_valid=0, frame_err=0, overrun_err=0.
  - Synchroniser flops set to 1; state=IDLE; counters=0.
- rx passes through a 2-flop synchroniser (rx_s) every clk. All state decisions use rx_s and occur only on clks with baud_tick=1.
- tick_cnt width is $clog2(OVERSAMPLE); bit_idx width is $clog2(DATA_BITS+1).
- IDLE:
  - On a tick with rx_s=0: go to START, tick_cnt=0.
- START:
  - Each tick, tick_cnt+1.
  - On the tick where tick_cnt==OVERSAMPLE/2-1:
    - rx_s=0: go to DATA, tick_cnt=0, bit_idx=0.
    - rx_s=1: false start; return to IDLE with no output.
- DATA:
  - Each tick, tick_cnt+1.
  - On the tick where tick_cnt==OVERSAMPLE-1: shift rx_s into the shift register MSB (right shift, so the first bit lands in LSB), tick_cnt=0, bit_idx+1.
  - After the DATA_BITS-th sample: go to STOP.
- STOP:
  - On the tick where tick_cnt==OVERSAMPLE-1, sample rx_s.
  - rx_s=1, frame accepted:
    - If the holding register is free, or is drained in the same clk (rx_valid & rx_ready): rx_data<=shift register, rx_valid<=1.
    - Otherwise: overrun_err pulses 1 clk; the new byte is dropped; the old rx_data/rx_valid are unchanged.
    - Go to IDLE.
  - rx_s=0: frame_err pulses 1 clk; byte discarded; go to WAIT_IDLE.
- WAIT_IDLE:
  - On a tick with rx_s=1: go to IDLE. This blocks break/stuck-low lines from producing repeated frames.
- Output handshake:
  - rx_valid clears the clk after rx_valid & rx_ready, unless a new byte loads in that same clk, in which case it stays 1 with the new data.
  - rx_ready while rx_valid=0 has no effect.
- Latency: rx_valid rises 1 clk after the baud_tick on which the stop bit is sampled, i.e. ~(DATA_BITS+1.5) bit periods after the start-bit falling edge.
- Idle/tick behaviour: baud_tick held 0 freezes the FSM and counters; the handshake logic still runs every clk.
- frame_err and overrun_err are never asserted simultaneously.
- Reset mid-frame aborts immediately. After release, the receiver hunts for a fresh start bit in IDLE. The remainder of an interrupted frame may be seen as a start only if rx_s=0 at a tick.

Test Plan:
- Basic receive:
  - Stimulus: baud_tick every 54 clk, rx frame for 0xA5 (bits 1,0,1,0,0,1,0,1 after start, stop=1), rx_ready=1.
  - Response: single rx_valid, rx_data=0xA5, no error pulses.
- Glitch rejection:
  - Stimulus: rx low for 4 ticks, then high.
  - Response: state returns to IDLE, rx_valid stays 0, no errors; a following 0x3C frame is received correctly.
- Framing error:
  - Stimulus: frame 0x55 with stop bit driven 0 for 2 bit periods.
  - Response: frame_err pulse 1 clk, rx_valid=0; no new frame while rx stays low. Next valid 0x0F frame is received.
- Overrun:
  - Stimulus: rx_ready=0; send 0x11 then 0x22 back-to-back.
  - Response: rx_data=0x11 with rx_valid=1, and an overrun_err pulse at the 0x22 stop sample. Raising rx_ready then yields 0x11 only.
- Simultaneous drain and load:
  - Stimulus: hold 0x11, assert rx_ready exactly on the clk the 0x22 stop sample loads.
  - Response: no overrun_err; rx_valid stays 1 with rx_data=0x22.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 during data bit 3 of 0xFF; release with rx high; send 0x81.
  - Response: outputs 0 during reset; only 0x81 is delivered.
